// File: rtl/ubin_acc.sv
// Unary-to-binary accumulator: counts ones over 2^WINLOG enabled samples of a unary stream.
// Latency: result valid the cycle after the last-sample edge; 2^WINLOG+1 cycles from iStart with no gaps.
// Backpressure: one-entry result register; a result arriving while it is held and not accepted is dropped and flags oOvr.
`ifndef INWD
`define INWD 4
`endif

module ubin_acc #(
   parameter int INWD   = `INWD,
   parameter int WINLOG = 2 * INWD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              iBit,
   input  logic              iEn,
   input  logic              iStart,
   input  logic              iCont,
   input  logic              iReady,
   input  logic              iClrOvr,
   output logic              oValid,
   output logic [WINLOG:0]   oCnt,
   output logic [INWD-1:0]   oVal,
   output logic              oBusy,
   output logic              oOvr
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t              state;
   logic [WINLOG:0]     acc;
   logic [WINLOG-1:0]   win_cnt;
   logic [WINLOG:0]     final_cnt;
   logic [INWD-1:0]     final_val;
   logic                last_sample;

   // Count including the current sample, and its saturated INWD-bit view.
   // Only the all-ones window (top bit set) can overflow the shifted range.
   always_comb begin
      final_cnt   = acc + {{WINLOG{1'b0}}, iBit};
      final_val   = final_cnt[WINLOG] ? {INWD{1'b1}} : final_cnt[WINLOG-1 -: INWD];
      last_sample = (state == RUN) && iEn && (win_cnt == {WINLOG{1'b1}});
   end

   // Busy is a straight view of the registered FSM state.
   assign oBusy = (state == RUN);

   // FSM, accumulator, window counter, result register and sticky overrun flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         acc     <= '0;
         win_cnt <= '0;
         oValid  <= 1'b0;
         oCnt    <= '0;
         oVal    <= '0;
         oOvr    <= 1'b0;
      end else begin
         // Consumption; a refill later in this block overrides it.
         if (oValid && iReady) begin
            oValid <= 1'b0;
         end
         // Clear first so a same-edge overrun set takes priority.
         if (iClrOvr) begin
            oOvr <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (iStart) begin
                  state   <= RUN;
                  acc     <= '0;
                  win_cnt <= '0;
               end
            end
            RUN: begin
               if (last_sample) begin
                  acc     <= '0;
                  win_cnt <= '0;
                  state   <= iCont ? RUN : IDLE;
                  if (!oValid || iReady) begin
                     oValid <= 1'b1;
                     oCnt   <= final_cnt;
                     oVal   <= final_val;
                  end else begin
                     oOvr <= 1'b1;
                  end
               end else if (iEn) begin
                  acc     <= final_cnt;
                  win_cnt <= win_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/ubin_acc.md
# ubin_acc

Unary-to-binary accumulator that sits directly downstream of the unary multiplier and consumes its single-bit product stream. It counts ones over a fixed window of 2^WINLOG enabled samples and produces a full-precision count plus a saturated INWD-bit binary value. The result is presented on a valid/ready handshake with a one-entry result register and a sticky overrun flag. It supports single-shot and back-to-back (continuous) windows.

## Interface
- INWD, default `INWD: binary width of the multiplier operands and of oVal.
- WINLOG, default 2*INWD: log2 of the window length in enabled samples; legal range INWD..2*INWD.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- iBit  in  1  unary bitstream sample (multiplier oC).
- iEn  in  1  sample qualifier; only cycles with iEn=1 count toward the window.
- iStart  in  1  starts a window; honoured only in IDLE.
- iCont  in  1  sampled at window end; if 1, the next window starts immediately.
- iReady  in  1  downstream accepts the result.
- oValid  out  1  result register holds an unconsumed result.
- oCnt  out  WINLOG+1  ones count of the last completed window (0..2^WINLOG).
- oVal  out  INWD  min(oCnt >> (WINLOG-INWD), 2^INWD-1).
- oBusy  out  1  state is RUN.
- oOvr  out  1  sticky: a window completed while oValid=1 and iReady=0.
- iClrOvr  in  1  clears oOvr.

## Operation
- FSM states:
  - IDLE: iStart=1 moves to RUN at the next edge. The accumulator and the window counter clear at that edge.
  - RUN: each cycle with iEn=1 adds iBit to acc (WINLOG+1 bits) and increments winCnt (WINLOG bits).
- Last sample: a cycle in RUN with iEn=1 and winCnt = 2^WINLOG-1. At that edge:
  - the final count acc+iBit is the result;
  - winCnt wraps to 0 and acc clears;
  - state becomes RUN if iCont=1, else IDLE.
- Result register:
  - Loads the result at the last-sample edge if oValid=0, or if oValid=1 and iReady=1 in that cycle (consume and refill on the same edge).
  - If oValid=1 and iReady=0, the new result is dropped, the old result is kept, and oOvr is set.
- Handshake: a result is consumed on an edge with oValid=1 and iReady=1; oValid then falls unless a refill happens on the same edge. oCnt and oVal stay stable while oValid=1.
- iStart while in RUN is ignored. iEn=0 cycles freeze acc and winCnt.
- oVal saturation: only oCnt = 2^WINLOG (all ones) can exceed the range; it maps to 2^INWD-1.
- oOvr: set has priority over iClrOvr when both occur on the same edge.

## Timing
- Reset values: state IDLE, acc 0, winCnt 0, oValid 0, oCnt 0, oVal 0, oBusy 0, oOvr 0.
- The iStart cycle itself is not sampled. The first sample is the cycle after the edge that captured iStart.
- Latency: oValid rises in the cycle immediately after the last-sample edge. A window with no iEn gaps therefore takes 2^WINLOG+1 cycles from iStart to oValid.
- Continuous mode: no dead cycle between windows. The cycle after the last sample is sample 0 of the next window.
- oBusy is registered state, not a combinational decode of iStart.
- Reset asserted mid-window: all state clears asynchronously. The partial count is discarded and no result is produced.
- All outputs are registered. There is no combinational path from iReady to oValid or from iBit to any output.

## Test plan
All scenarios use INWD=4, WINLOG=8 (window of 256 samples).
- iBit=1 and iEn=1 for 256 samples after iStart, iReady=1 -> oValid one cycle after the last sample; oCnt=256; oVal=15 (saturated).
- iBit=0 for the whole window -> oCnt=0, oVal=0.
- iBit driven by the unary multiplier with iA=8 and iB=8, both blocks reset together, iStart in the first cycle after reset, samples aligned to the multiplier's first output -> oCnt=64, oVal=4.
- iEn toggling 1,0,1,0 with iBit=1 -> the window completes after 256 enabled samples (~512 cycles); oCnt=256; the iBit values on iEn=0 cycles are ignored.
- iCont=1, iReady=0, two windows of ones -> first result retained (oCnt=256), oOvr=1; one iClrOvr pulse -> oOvr=0; an iReady pulse -> oValid=0.
- rst_n asserted at sample 100 of a window, released, then a fresh full window of ones -> no result from the aborted window; the fresh window gives oCnt=256 with oValid pulsing exactly once.
